// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int UART_W_DEF        = 5;
  localparam int UART_B_DEF        = 8;
  localparam int UART_MIN_BAUD_DIV = 16;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - circular first-word fall-through RX FIFO with sticky overrun.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int W = UART_W_DEF,
  parameter int B = UART_B_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [B-1:0] wdata,
  input  logic         pop,
  output logic [B-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic         overrun
);

  localparam logic [W:0] DEPTH = {1'b1, {W{1'b0}}};

  logic [B-1:0] mem [2**W];
  logic [W-1:0] wr_ptr;
  logic [W-1:0] rd_ptr;
  logic [W:0]   count;
  logic         rd_ok;
  logic         wr_ok;
  logic         drop;

  assign full  = (count == DEPTH);
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // A read frees the head slot this cycle, so a push while full is still accepted.
  assign rd_ok = pop & ~empty;
  assign wr_ok = push & (~full | rd_ok);
  assign drop  = push & full & ~rd_ok;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overrun <= 1'b1;
      end else if (rd_ok) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_rx_top.sv
// rtl/uart_rx_top.sv - UART receiver: synchronizer, frame FSM, shifter and RX FIFO.
// Stop-bit checking and the frame_err flag exist only when UART_RX_FRAME_ERR_EN is defined.
module uart_rx_top
  import uart_pkg::*;
#(
  parameter int W = UART_W_DEF,
  parameter int B = UART_B_DEF
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic [15:0]  baud_div,
  input  logic         UART_Control_Register_rx_Active,
  input  logic         UART_Data_Read_Register_enable,
  output logic [B-1:0] UART_Data_Read_Register_rdata,
  output logic         UART_Status_Register_rx_full,
  output logic         UART_Status_Register_rx_empty,
  output logic         UART_Status_Register_rx_overrun,
`ifdef UART_RX_FRAME_ERR_EN
  output logic         UART_Status_Register_rx_frame_err,
`endif
  input  logic         UART_rx_i,
  output logic         UART_Data_Receive_Tick
);

  localparam int BCW = (B > 1) ? $clog2(B) : 1;

  rx_state_e    state;
  rx_state_e    next;
  logic [1:0]   sync;
  logic         rx_s;
  logic         rx_q;
  logic         fall;
  logic         active;
  logic [15:0]  div_eff;
  logic [15:0]  div_q;
  logic [15:0]  cnt;
  logic         cnt_zero;
  logic [BCW-1:0] bit_cnt;
  logic         last_bit;
  logic [B-1:0] shreg;
  logic         push;
`ifdef UART_RX_FRAME_ERR_EN
  logic         ferr_set;
  logic         read_acc;
`endif

  assign rx_s     = sync[1];
  assign fall     = rx_q & ~rx_s;
  assign active   = UART_Control_Register_rx_Active;
  assign cnt_zero = (cnt == '0);
  assign last_bit = (bit_cnt == BCW'(B - 1));
  // Below the minimum divider the receiver is undefined; clamp so the counters stay sane.
  assign div_eff  = (baud_div < 16'(UART_MIN_BAUD_DIV)) ? 16'(UART_MIN_BAUD_DIV) : baud_div;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync <= 2'b11;
      rx_q <= 1'b1;
    end else begin
      sync <= {sync[0], UART_rx_i};
      rx_q <= rx_s;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    push = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    ferr_set = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (active && fall) next = START;
      end
      START: begin
        if (!active) next = IDLE;
        else if (cnt_zero) next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (!active) next = IDLE;
        else if (cnt_zero && last_bit) next = STOP;
      end
      STOP: begin
        if (!active) begin
          next = IDLE;
        end else if (cnt_zero) begin
          next = IDLE;
`ifdef UART_RX_FRAME_ERR_EN
          if (rx_s) push = 1'b1;
          else ferr_set = 1'b1;
`else
          push = 1'b1;
`endif
        end
      end
      default: next = IDLE;
    endcase
  end

  // The divider is captured on every state change so mid-frame edits wait for the next one.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt     <= '0;
      div_q   <= 16'(UART_MIN_BAUD_DIV);
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (next != state) begin
        div_q <= div_eff;
        cnt   <= (next == START) ? (div_eff >> 1) - 16'd1 : div_eff - 16'd1;
      end else if (state != IDLE) begin
        cnt <= cnt_zero ? div_q - 16'd1 : cnt - 16'd1;
      end
      if (state == IDLE && next == START) begin
        bit_cnt <= '0;
      end else if (state == DATA && cnt_zero) begin
        bit_cnt <= bit_cnt + 1'b1;
        shreg   <= {rx_s, shreg[B-1:1]};
      end
    end
  end

  assign UART_Data_Receive_Tick = push;

  uart_rx_fifo #(
    .W (W),
    .B (B)
  ) u_fifo (
    .clk     (clk_i),
    .rst_n   (rstn_i),
    .push    (push),
    .wdata   (shreg),
    .pop     (UART_Data_Read_Register_enable),
    .rdata   (UART_Data_Read_Register_rdata),
    .full    (UART_Status_Register_rx_full),
    .empty   (UART_Status_Register_rx_empty),
    .overrun (UART_Status_Register_rx_overrun)
  );

`ifdef UART_RX_FRAME_ERR_EN
  assign read_acc = UART_Data_Read_Register_enable & ~UART_Status_Register_rx_empty;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      UART_Status_Register_rx_frame_err <= 1'b0;
    end else if (ferr_set) begin
      UART_Status_Register_rx_frame_err <= 1'b1;
    end else if (read_acc) begin
      UART_Status_Register_rx_frame_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_top.sv
// tb/tb_uart_rx_top.sv - directed self-checking bench for uart_rx_top.
module tb_uart_rx_top;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] baud_div = 16'd868;
  logic        active = 1'b0;
  logic        rd_en = 1'b0;
  logic        rx = 1'b1;
  logic [7:0]  rdata;
  logic        full;
  logic        empty;
  logic        overrun;
  logic        tick;
`ifdef UART_RX_FRAME_ERR_EN
  logic        frame_err;
`endif

  int          checks = 0;
  int          failures = 0;
  int          ticks = 0;
  logic [7:0]  rnd [32];
  logic [7:0]  d;
  logic [7:0]  ab;

  uart_rx_top dut (
    .clk_i                             (clk),
    .rstn_i                            (rstn),
    .baud_div                          (baud_div),
    .UART_Control_Register_rx_Active   (active),
    .UART_Data_Read_Register_enable    (rd_en),
    .UART_Data_Read_Register_rdata     (rdata),
    .UART_Status_Register_rx_full      (full),
    .UART_Status_Register_rx_empty     (empty),
    .UART_Status_Register_rx_overrun   (overrun),
`ifdef UART_RX_FRAME_ERR_EN
    .UART_Status_Register_rx_frame_err (frame_err),
`endif
    .UART_rx_i                         (rx),
    .UART_Data_Receive_Tick            (tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (tick) ticks <= ticks + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input int bit_cyc);
    rx = 1'b0;
    #(bit_cyc * 10);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      #(bit_cyc * 10);
    end
    rx = stop;
    #(bit_cyc * 10);
    rx = 1'b1;
  endtask

  task automatic read_byte(output logic [7:0] v);
    @(negedge clk);
    v = rdata;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_tick", 32'(tick), 0);
`ifdef UART_RX_FRAME_ERR_EN
    check("rst_frame_err", 32'(frame_err), 0);
`endif
    rstn = 1'b1;
    active = 1'b1;
    @(negedge clk);

    // 0xA5 at full-rate divider
    send_frame(8'hA5, 1'b1, 868);
    repeat (4) @(negedge clk);
    check("a5_ticks", 32'(ticks), 1);
    check("a5_empty", 32'(empty), 0);
    check("a5_rdata", 32'(rdata), 32'hA5);
    read_byte(d);
    check("a5_read_empty", 32'(empty), 1);

    // 300 ns glitch is shorter than half a bit
    rx = 1'b0;
    #300;
    rx = 1'b1;
    repeat (1000) @(negedge clk);
    check("glitch_ticks", 32'(ticks), 1);
    check("glitch_empty", 32'(empty), 1);
    check("glitch_idle", 32'(dut.state), 32'(uart_pkg::IDLE));

    // drop rx_Active during bit 3 of 0x77
    baud_div = 16'd16;
    ab = 8'h77;
    rx = 1'b0;
    #160;
    for (int i = 0; i < 3; i++) begin
      rx = ab[i];
      #160;
    end
    rx = ab[3];
    #80;
    active = 1'b0;
    #80;
    rx = 1'b1;
    repeat (200) @(negedge clk);
    active = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_ticks", 32'(ticks), 1);
    check("abort_empty", 32'(empty), 1);
    send_frame(8'h5A, 1'b1, 16);
    repeat (4) @(negedge clk);
    check("abort_5a_ticks", 32'(ticks), 2);
    check("abort_5a_rdata", 32'(rdata), 32'h5A);

    // reset pulse mid-frame while the FIFO still holds 0x5A
    rx = 1'b0;
    #160;
    for (int i = 0; i < 4; i++) begin
      rx = ab[i];
      #160;
    end
    rx = ab[4];
    #80;
    rstn = 1'b0;
    #20;
    rstn = 1'b1;
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("rstmid_ticks", 32'(ticks), 2);
    check("rstmid_empty", 32'(empty), 1);
    send_frame(8'h5A, 1'b1, 16);
    repeat (4) @(negedge clk);
    check("rstmid_5a_ticks", 32'(ticks), 3);
    check("rstmid_5a_rdata", 32'(rdata), 32'h5A);
    read_byte(d);
    check("rstmid_read_empty", 32'(empty), 1);

    // 32 back-to-back frames fill the FIFO across the pointer wrap
    for (int i = 0; i < 32; i++) rnd[i] = 8'($urandom);
    for (int i = 0; i < 32; i++) send_frame(rnd[i], 1'b1, 16);
    repeat (4) @(negedge clk);
    check("fill_ticks", 32'(ticks), 35);
    check("fill_full", 32'(full), 1);
    check("fill_overrun", 32'(overrun), 0);

    send_frame(8'h3C, 1'b1, 16);
    repeat (4) @(negedge clk);
    check("ovr_ticks", 32'(ticks), 36);
    check("ovr_overrun", 32'(overrun), 1);
    check("ovr_full", 32'(full), 1);

    for (int i = 0; i < 32; i++) begin
      read_byte(d);
      check($sformatf("drain_%0d", i), 32'(d), 32'(rnd[i]));
      if (i == 0) begin
        check("drain_overrun_clr", 32'(overrun), 0);
        check("drain_not_full", 32'(full), 0);
      end
    end
    check("drain_empty", 32'(empty), 1);

    // 0x81 with a zero stop bit
    send_frame(8'h81, 1'b0, 16);
    repeat (4) @(negedge clk);
`ifdef UART_RX_FRAME_ERR_EN
    check("ferr_ticks", 32'(ticks), 36);
    check("ferr_empty", 32'(empty), 1);
    check("ferr_flag", 32'(frame_err), 1);
`else
    check("stop0_ticks", 32'(ticks), 37);
    check("stop0_empty", 32'(empty), 0);
    check("stop0_rdata", 32'(rdata), 32'h81);
    read_byte(d);
    check("stop0_read_empty", 32'(empty), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_top.md
UART_RX_TOP -- requirements
Module: uart_rx_top

Interface
REQ-001 Parameter W, default 5, meaning FIFO address bits (depth 2**W = 32 entries).
REQ-002 Parameter B, default 8, meaning data bits per frame and FIFO word width.
REQ-003 clk_i  input  1  system clock, all state on rising edge.
REQ-004 rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 baud_div  input  16  clk_i cycles per UART bit (868 = 115200 baud at 100 MHz).
REQ-006 UART_Control_Register_rx_Active  input  1  receiver enable.
REQ-007 UART_Data_Read_Register_enable  input  1  one-cycle pop request for the FIFO head.
REQ-008 UART_Data_Read_Register_rdata  output  B  FIFO head word, first-word fall-through.
REQ-009 UART_Status_Register_rx_full  output  1  FIFO holds 2**W words.
REQ-010 UART_Status_Register_rx_empty  output  1  FIFO holds 0 words.
REQ-011 UART_Status_Register_rx_overrun  output  1  sticky, a received byte was dropped because the FIFO was full.
REQ-012 UART_rx_i  input  1  asynchronous serial line, idle high.
REQ-013 UART_Data_Receive_Tick  output  1  one-cycle pulse per accepted frame.

Function
REQ-014 UART_rx_i SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-015 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-016 IDLE: on a synchronized 1->0 transition with rx_Active=1, go to START and clear the bit counter.
REQ-017 START: wait baud_div>>1 cycles; if the line is 0, go to DATA; else return to IDLE as a glitch, with no write and no tick.
REQ-018 DATA: sample the line every baud_div cycles, shifting LSB first; after B samples go to STOP.
REQ-019 STOP: after baud_div cycles, sample the stop bit, push the byte to the FIFO (REQ-026), pulse UART_Data_Receive_Tick in the same cycle, and return to IDLE.
REQ-020 rx_Active deasserted in any non-IDLE state SHALL return the FSM to IDLE on the next edge and discard the partial byte; FIFO contents are kept.
REQ-021 The baud counter SHALL be 16 bits and reload on every state change; operation is defined only for baud_div >= 16.
REQ-022 A baud_div change takes effect at the next state change.
REQ-023 The FIFO SHALL be circular: pointers are W bits and wrap 2**W-1 -> 0; full/empty come from a W+1-bit count.
REQ-024 rdata SHALL equal the head word combinationally; when empty, rdata is don't-care.
REQ-025 A read with empty=1 SHALL be ignored.
REQ-026 A push with full=1 and no simultaneous read SHALL drop the byte, set overrun, and still pulse the tick.
REQ-027 A simultaneous push and read SHALL perform both, leaving the count unchanged; this applies even when full, with no overrun.
REQ-028 Status flags SHALL update on the edge after the causing write or read.
REQ-029 overrun SHALL clear on any accepted read; a set in the same cycle as a clear wins.

Reset
REQ-030 rstn_i=0 SHALL asynchronously force the FSM to IDLE and clear the counters, shift register, FIFO pointers and count.
REQ-031 Reset values: empty=1, full=0, overrun=0, tick=0, synchronizer flops=1; rdata is don't-care.
REQ-032 Reset mid-frame SHALL discard the frame; after release, reception resumes at the next falling edge.

Configuration
REQ-033 Macro UART_RX_FRAME_ERR_EN defined: a stop-bit sample of 0 SHALL drop the byte, give no tick, and set sticky output UART_Status_Register_rx_frame_err (1 bit, reset 0, cleared by an accepted read).
REQ-034 UART_RX_FRAME_ERR_EN undefined: the stop bit is not checked, every frame is pushed, and the frame_err port does not exist.

Structure
REQ-035 Package uart_pkg SHALL hold the FSM state enum typedef, default W/B constants and the minimum baud_div constant (16).
REQ-036 Sub-module uart_rx_fifo SHALL implement REQ-023..REQ-029; the FSM, synchronizer and shifter stay in uart_rx_top.

Verification
REQ-037 baud_div=868, rx_Active=1; drive 0xA5 8N1 at 8680 ns/bit -> tick once, empty=0, rdata=0xA5; one read -> empty=1.
REQ-038 Drive 32 random bytes back-to-back -> full=1 after the 32nd; 32 reads return the same bytes in order, with the pointer wrap exercised.
REQ-039 Full FIFO plus one extra byte 0x3C -> overrun=1, tick pulses, 0x3C absent; first read -> overrun=0.
REQ-040 Line low for 300 ns then high -> no tick, FSM back in IDLE, empty stays 1.
REQ-041 Drop rx_Active during bit 3, or pulse rstn_i low mid-frame -> no write; next full frame 0x5A is received correctly.
REQ-042 UART_RX_FRAME_ERR_EN defined; byte 0x81 with stop bit 0 -> no tick, FIFO unchanged, frame_err=1.
